ahb_timer: RTL and testbench
============================

// Module: ahb_timer
// PURPOSE
//  AHB slave peripheral: programmable down-counting timer with interrupt flag, occupying a slave
//  slot on the ahb fabric beside the IM/DM/UART slave wrappers. Decodes HTRANS/HADDR itself,
//  returns HREADY/HRESP/HSPLIT/HRDATA to the bus mux, drives a level interrupt to the cpu.
// PARAMETERS
//  CNT_WIDTH    32  width of LOAD/VALUE registers (<=32; upper HRDATA bits read 0)
//  PRESC_WIDTH  8   width of CTRL.PRESC prescaler field (only with TIMER_PRESCALE_EN)
// PORTS
//  HCLK       in   1   single clock, all state on rising edge
//  HRESETn    in   1   asynchronous, active-low reset
//  HSEL       in   1   slave select from ahb decoder
//  HTRANS     in   2   IDLE=00 BUSY=01 NONSEQ=10 SEQ=11
//  HWRITE     in   1   1=write
//  HSIZE      in   3   only 3'b010 (word) legal
//  HBURST     in   3   ignored; each beat handled as single
//  HADDR      in   32  bits [3:2] select register, others ignored
//  HWDATA     in   32  write data, sampled in data phase
//  HREADY_IN  in   1   muxed bus HREADY; address phase valid only when high
//  HREADY     out  1   this slave's ready
//  HRESP      out  2   OKAY=00 ERROR=01
//  HSPLIT     out  16  tied 0
//  HRDATA     out  32  read data
//  irq        out  1   STATUS.IF & CTRL.IE
// BEHAVIOUR
//  Reset: HREADY=1, HRESP=OKAY, HRDATA=0, irq=0; CTRL/LOAD/VALUE/STATUS=0; FSM=ST_IDLE.
//  Regs (HADDR[3:2]): 0 CTRL {[0]EN,[1]PERIODIC,[2]IE,[15:8]PRESC}; 1 LOAD; 2 VALUE (RO, writes
//   ignored); 3 STATUS {[0]IF} write-1-to-clear. Unused bits read 0.
//  Address phase accepted when HSEL & HTRANS[1] & HREADY_IN; addr/write/size latched.
//  FSM: ST_IDLE -> (acc write, word) ST_WDATA | (acc read, word) ST_RWAIT | (acc, HSIZE!=word) ST_ERR1.
//   ST_WDATA: HREADY=1, HWDATA written at cycle end; new address may be accepted same cycle.
//   ST_RWAIT: HREADY=0, HRDATA<=reg -> ST_RDATA. ST_RDATA: HREADY=1, HRDATA valid; may accept next.
//   ST_ERR1: HREADY=0,HRESP=ERROR -> ST_ERR2: HREADY=1,HRESP=ERROR; no register effect.
//   Back-to-back: from ST_WDATA/ST_RDATA/ST_ERR2 branch as from ST_IDLE, else return ST_IDLE.
//  Read latency: 1 wait state. Write: 0 wait states. BUSY/IDLE transfers: OKAY, 0 waits.
//  Counter: tick every cycle while EN. On tick: VALUE!=0 -> VALUE-1; VALUE==0 -> IF<=1 and
//   PERIODIC ? VALUE<=LOAD : EN<=0 (VALUE stays 0). Write to LOAD also sets VALUE=LOAD.
//   Write CTRL with EN 0->1 does not reload VALUE. LOAD=0 with PERIODIC: IF every tick.
//  Simultaneous: hw IF set and W1C same cycle -> IF=1 (set wins). LOAD write and tick same
//   cycle -> VALUE=LOAD (write wins), no IF from that tick. Subtract never wraps below 0.
//  Reset mid-transfer: FSM to ST_IDLE, HREADY=1 immediately (async); pending write dropped.
// CONFIGURATION
//  TIMER_PRESCALE_EN defined: PRESC_WIDTH-bit prescaler; tick asserted once per (PRESC+1)
//   cycles while EN; prescaler cleared on EN=0 or LOAD write. CTRL[15:8] read/write.
//  Undefined: tick every cycle while EN; CTRL[15:8] read 0, writes ignored.
// STRUCTURE
//  soc_ahb_pkg: HTRANS/HRESP/HSIZE encodings, TMR_CTRL/LOAD/VALUE/STATUS offsets, CTRL bit idx.
//  Sub-module timer_core: prescaler, VALUE counter, reload/one-shot, IF set; bus FSM + register
//   file stay in ahb_timer.
// TESTING
//  1 Reset: HRESETn low -> HREADY=1, HRESP=00, HRDATA=0, irq=0; read VALUE after -> 0.
//  2 Write LOAD=5, CTRL=0x7 (EN,PERIODIC,IE) -> VALUE 5,4..0, IF=1 and irq=1 on tick after 0,
//    VALUE reloads 5; write STATUS=1 -> irq=0 next cycle, re-asserts 6 ticks later.
//  3 One-shot: LOAD=3, CTRL=0x1 -> after 4 ticks IF=1, CTRL.EN reads 0, VALUE holds 0.
//  4 Read CTRL -> exactly one HREADY=0 cycle, data on next; back-to-back write then read ok.
//  5 HSIZE=3'b000 write to LOAD -> ERROR,HREADY=0 then ERROR,HREADY=1; LOAD unchanged.
//  6 TIMER_PRESCALE_EN, PRESC=3, LOAD=2 -> VALUE decrements every 4 cycles; W1C coinciding
//    with IF set leaves IF=1.

Source files
------------

// File: rtl/soc_ahb_pkg.sv
// Shared AHB encodings, timer register map and bus FSM states for the ahb_timer slave.
package soc_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [1:0] {
    TMR_CTRL   = 2'd0,
    TMR_LOAD   = 2'd1,
    TMR_VALUE  = 2'd2,
    TMR_STATUS = 2'd3
  } tmr_reg_e;

  localparam int CTRL_EN        = 0;
  localparam int CTRL_PERIODIC  = 1;
  localparam int CTRL_IE        = 2;
  localparam int CTRL_PRESC_LSB = 8;
  localparam int STATUS_IF      = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_RWAIT,
    ST_RDATA,
    ST_ERR1,
    ST_ERR2
  } ahb_st_e;

  // Next state for a slot that may start a new transfer.
  function automatic ahb_st_e branch_st(input logic acc, input logic wr, input logic [2:0] size);
    if (!acc)               return ST_IDLE;
    if (size != HSIZE_WORD) return ST_ERR1;
    return wr ? ST_WDATA : ST_RWAIT;
  endfunction

endpackage

// File: rtl/timer_core.sv
// Timer datapath: optional prescaler, LOAD/VALUE down-counter, periodic reload or one-shot stop,
// interrupt flag with hardware set taking priority over software clear.
module timer_core #(
  parameter int CNT_WIDTH   = 32,
  parameter int PRESC_WIDTH = 8
) (
  input  logic                   gclk,
  input  logic                   grst_n,
  input  logic                   en,
  input  logic                   periodic,
  input  logic [PRESC_WIDTH-1:0] presc,
  input  logic                   load_wr,
  input  logic [CNT_WIDTH-1:0]   load_val,
  input  logic                   if_clr,
  output logic [CNT_WIDTH-1:0]   load_q,
  output logic [CNT_WIDTH-1:0]   value_q,
  output logic                   if_q,
  output logic                   en_clr
);

  logic [PRESC_WIDTH-1:0] pcnt;
  logic                   tick;
  logic                   expire;

  // With presc tied to zero the prescaler degenerates to a tick every enabled cycle.
  assign tick   = en && (pcnt == presc);
  assign expire = tick && !load_wr && (value_q == '0);
  assign en_clr = expire && !periodic;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)              pcnt <= '0;
    else if (!en || load_wr)  pcnt <= '0;
    else if (tick)            pcnt <= '0;
    else                      pcnt <= pcnt + 1'b1;
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      load_q  <= '0;
      value_q <= '0;
    end else if (load_wr) begin
      load_q  <= load_val;
      value_q <= load_val;
    end else if (tick) begin
      if (value_q != '0) value_q <= value_q - 1'b1;
      else if (periodic) value_q <= load_q;
    end
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)     if_q <= 1'b0;
    else if (expire) if_q <= 1'b1;
    else if (if_clr) if_q <= 1'b0;
  end

endmodule

// File: rtl/ahb_timer.sv
// AHB slave wrapper for the down-counting timer: bus FSM, register file, read mux, irq.
// Optional prescaler in CTRL[15:8] is built only when TIMER_PRESCALE_EN is defined.
module ahb_timer
  import soc_ahb_pkg::*;
#(
  parameter int CNT_WIDTH   = 32,
  parameter int PRESC_WIDTH = 8
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  input  logic        HREADY_IN,
  output logic        HREADY,
  output logic [1:0]  HRESP,
  output logic [15:0] HSPLIT,
  output logic [31:0] HRDATA,
  output logic        irq
);

  ahb_st_e                st, st_nxt;
  tmr_reg_e               addr_q;
  logic                   acc, can_acc, wr_en, load_wr, if_clr, en_clr;
  logic                   en_q, periodic_q, ie_q, if_q;
  logic [PRESC_WIDTH-1:0] presc_q;
  logic [CNT_WIDTH-1:0]   load_q, value_q;
  logic [31:0]            rd_mux;
  logic                   unused;

  assign unused  = ^{HBURST, HADDR[31:4], HADDR[1:0], HTRANS[0]};
  assign HSPLIT  = '0;
  assign acc     = HSEL && HTRANS[1] && HREADY_IN;
  assign can_acc = (st != ST_RWAIT) && (st != ST_ERR1);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) st <= ST_IDLE;
    else          st <= st_nxt;
  end

  always_comb begin
    st_nxt = ST_IDLE;
    case (st)
      ST_RWAIT: st_nxt = ST_RDATA;
      ST_ERR1:  st_nxt = ST_ERR2;
      default:  st_nxt = branch_st(acc, HWRITE, HSIZE);
    endcase
  end

  always_comb begin
    HREADY = 1'b1;
    HRESP  = HRESP_OKAY;
    case (st)
      ST_RWAIT: HREADY = 1'b0;
      ST_ERR1: begin
        HREADY = 1'b0;
        HRESP  = HRESP_ERROR;
      end
      ST_ERR2:  HRESP  = HRESP_ERROR;
      default: ;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)            addr_q <= TMR_CTRL;
    else if (acc && can_acc) addr_q <= tmr_reg_e'(HADDR[3:2]);
  end

  assign wr_en   = (st == ST_WDATA);
  assign load_wr = wr_en && (addr_q == TMR_LOAD);
  assign if_clr  = wr_en && (addr_q == TMR_STATUS) && HWDATA[STATUS_IF];

  // A CTRL write in the same cycle as a one-shot expiry keeps the written EN.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      en_q       <= 1'b0;
      periodic_q <= 1'b0;
      ie_q       <= 1'b0;
    end else if (wr_en && addr_q == TMR_CTRL) begin
      en_q       <= HWDATA[CTRL_EN];
      periodic_q <= HWDATA[CTRL_PERIODIC];
      ie_q       <= HWDATA[CTRL_IE];
    end else if (en_clr) begin
      en_q       <= 1'b0;
    end
  end

`ifdef TIMER_PRESCALE_EN
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)                           presc_q <= '0;
    else if (wr_en && addr_q == TMR_CTRL)   presc_q <= HWDATA[CTRL_PRESC_LSB +: PRESC_WIDTH];
  end
`else
  assign presc_q = '0;
`endif

  timer_core #(
    .CNT_WIDTH   (CNT_WIDTH),
    .PRESC_WIDTH (PRESC_WIDTH)
  ) u_core (
    .gclk     (HCLK),
    .grst_n   (HRESETn),
    .en       (en_q),
    .periodic (periodic_q),
    .presc    (presc_q),
    .load_wr  (load_wr),
    .load_val (HWDATA[CNT_WIDTH-1:0]),
    .if_clr   (if_clr),
    .load_q   (load_q),
    .value_q  (value_q),
    .if_q     (if_q),
    .en_clr   (en_clr)
  );

  always_comb begin
    rd_mux = '0;
    case (addr_q)
      TMR_CTRL: begin
        rd_mux[CTRL_EN]       = en_q;
        rd_mux[CTRL_PERIODIC] = periodic_q;
        rd_mux[CTRL_IE]       = ie_q;
`ifdef TIMER_PRESCALE_EN
        rd_mux[CTRL_PRESC_LSB +: PRESC_WIDTH] = presc_q;
`endif
      end
      TMR_LOAD:   rd_mux[CNT_WIDTH-1:0] = load_q;
      TMR_VALUE:  rd_mux[CNT_WIDTH-1:0] = value_q;
      TMR_STATUS: rd_mux[STATUS_IF]     = if_q;
      default: ;
    endcase
  end

  // Read data is captured during the wait state and held until the next read.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)            HRDATA <= '0;
    else if (st == ST_RWAIT) HRDATA <= rd_mux;
  end

  assign irq = if_q && ie_q;

endmodule

// File: tb/tb_ahb_timer.sv
// Directed bench for ahb_timer: reset, periodic/one-shot counting, irq, bus timing, errors,
// and (with TIMER_PRESCALE_EN) prescaled counting with a W1C/set collision.
module tb_ahb_timer;
  import soc_ahb_pkg::*;

  localparam logic [31:0] A_CTRL = 32'h0, A_LOAD = 32'h4, A_VALUE = 32'h8, A_STATUS = 32'hC;

  logic        HCLK, HRESETn, HSEL, HWRITE, HREADY_IN, HREADY, irq;
  logic [1:0]  HTRANS, HRESP;
  logic [2:0]  HSIZE, HBURST;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [15:0] HSPLIT;
  int          n_chk, n_err;

  assign HREADY_IN = HREADY;

  ahb_timer dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HADDR(HADDR), .HWDATA(HWDATA), .HREADY_IN(HREADY_IN),
    .HREADY(HREADY), .HRESP(HRESP), .HSPLIT(HSPLIT), .HRDATA(HRDATA), .irq(irq)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic bus_idle();
    HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0; HSIZE = HSIZE_WORD;
  endtask

  task automatic addr_ph(input logic [31:0] a, input logic wr, input logic [2:0] sz);
    HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = wr; HADDR = a; HSIZE = sz;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    addr_ph(a, 1'b1, HSIZE_WORD);
    step();
    bus_idle();
    HWDATA = d;
    step();
  endtask

  task automatic bus_rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr_ph(a, 1'b0, HSIZE_WORD);
    step();
    bus_idle();
    chk({tag, ".wait"}, 32'(HREADY), 32'd0);
    step();
    chk({tag, ".rdy"}, 32'(HREADY), 32'd1);
    chk(tag, HRDATA, exp);
  endtask

  // Write data phase overlapped with the address phase of a read.
  task automatic wr_rd(input logic [31:0] wa, input logic [31:0] wd, input logic [31:0] ra,
                       input logic [31:0] exp);
    addr_ph(wa, 1'b1, HSIZE_WORD);
    step();
    HWDATA = wd;
    addr_ph(ra, 1'b0, HSIZE_WORD);
    step();
    bus_idle();
    chk("b2b.wait", 32'(HREADY), 32'd0);
    step();
    chk("b2b.rdy", 32'(HREADY), 32'd1);
    chk("b2b.data", HRDATA, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_err = 0;
    HRESETn = 1'b0; HBURST = 3'b000; HADDR = '0; HWDATA = '0;
    bus_idle();

    // Reset state
    #12;
    chk("rst.hready", 32'(HREADY), 32'd1);
    chk("rst.hresp",  32'(HRESP),  32'd0);
    chk("rst.hrdata", HRDATA,      32'd0);
    chk("rst.irq",    32'(irq),    32'd0);
    chk("rst.hsplit", 32'(HSPLIT), 32'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    step();
    bus_rd("rst.value", A_VALUE, 32'd0);

    // Periodic with interrupt
    bus_wr(A_LOAD, 32'd5);
    bus_rd("per.v5", A_VALUE, 32'd5);
    bus_wr(A_CTRL, 32'h7);
    bus_rd("per.v4", A_VALUE, 32'd4);
    bus_rd("per.v2", A_VALUE, 32'd2);
    chk("per.irq0", 32'(irq), 32'd0);
    bus_rd("per.v0", A_VALUE, 32'd0);
    chk("per.irq1", 32'(irq), 32'd1);
    bus_wr(A_STATUS, 32'd1);
    chk("per.w1c", 32'(irq), 32'd0);
    repeat (3) step();
    chk("per.irq_pre", 32'(irq), 32'd0);
    step();
    chk("per.irq_again", 32'(irq), 32'd1);
    bus_wr(A_CTRL, 32'h0);
    bus_wr(A_STATUS, 32'd1);
    chk("per.irq_off", 32'(irq), 32'd0);

    // One-shot
    bus_wr(A_LOAD, 32'd3);
    bus_wr(A_CTRL, 32'h1);
    repeat (2) step();
    bus_rd("os.if_early", A_STATUS, 32'd0);
    chk("os.irq_masked", 32'(irq), 32'd0);
    bus_rd("os.if", A_STATUS, 32'd1);
    bus_rd("os.ctrl", A_CTRL, 32'd0);
    bus_rd("os.value", A_VALUE, 32'd0);
    bus_wr(A_STATUS, 32'd1);

    // Back-to-back write then read; VALUE is read-only
`ifdef TIMER_PRESCALE_EN
    wr_rd(A_CTRL, 32'h306, A_CTRL, 32'h306);
`else
    wr_rd(A_CTRL, 32'h306, A_CTRL, 32'h006);
`endif
    bus_wr(A_CTRL, 32'h0);
    bus_wr(A_VALUE, 32'h55);
    bus_rd("ro.value", A_VALUE, 32'd0);

    // Byte-size access -> two-cycle ERROR, no register effect
    addr_ph(A_LOAD, 1'b1, 3'b000);
    step();
    bus_idle();
    HWDATA = 32'hAB;
    chk("err1.hready", 32'(HREADY), 32'd0);
    chk("err1.hresp",  32'(HRESP),  32'(HRESP_ERROR));
    step();
    chk("err2.hready", 32'(HREADY), 32'd1);
    chk("err2.hresp",  32'(HRESP),  32'(HRESP_ERROR));
    step();
    chk("err.done", 32'(HRESP), 32'(HRESP_OKAY));
    bus_rd("err.load", A_LOAD, 32'd3);

    // BUSY transfer -> OKAY with no wait
    HSEL = 1'b1; HTRANS = HTRANS_BUSY;
    step();
    chk("busy.hready", 32'(HREADY), 32'd1);
    chk("busy.hresp",  32'(HRESP),  32'd0);
    bus_idle();
    step();

`ifdef TIMER_PRESCALE_EN
    // Prescale by 4; W1C lands on the same edge as the hardware set
    bus_wr(A_LOAD, 32'd2);
    bus_wr(A_CTRL, 32'h303);
    bus_rd("pre.v2a", A_VALUE, 32'd2);
    bus_rd("pre.v2b", A_VALUE, 32'd2);
    bus_rd("pre.v1a", A_VALUE, 32'd1);
    bus_rd("pre.v1b", A_VALUE, 32'd1);
    bus_rd("pre.v0",  A_VALUE, 32'd0);
    bus_wr(A_STATUS, 32'd1);
    bus_rd("pre.set_wins", A_STATUS, 32'd1);
    bus_wr(A_CTRL, 32'h0);
    bus_wr(A_STATUS, 32'd1);
    bus_rd("pre.cleared", A_STATUS, 32'd0);
`endif

    // Asynchronous reset during a read wait state
    addr_ph(A_CTRL, 1'b0, HSIZE_WORD);
    step();
    bus_idle();
    chk("mid.wait", 32'(HREADY), 32'd0);
    #2 HRESETn = 1'b0;
    #1;
    chk("mid.hready", 32'(HREADY), 32'd1);
    chk("mid.hrdata", HRDATA, 32'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    step();
    bus_rd("mid.load", A_LOAD, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
